// File: rtl/prog_counter_n_if.sv
// Control/status bundle for prog_counter_n: the master drives the controls,
// and the counter (slave) returns count, tc and done.
interface prog_counter_n_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;

    modport master (
        output en, load, load_val, dir, mode, limit, prescale,
        input  count, tc, done
    );

    modport slave (
        input  en, load, load_val, dir, mode, limit, prescale,
        output count, tc, done
    );
endinterface

// File: rtl/prog_counter_n.sv
// Programmable up/down counter with a clock-enable prescaler, four boundary
// modes (wrap, saturate, modulo, one-shot) and a registered terminal-count pulse.
module prog_counter_n #(
    parameter int               WIDTH     = 8,
    parameter int               PRE_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             rst,
    prog_counter_n_if.slave bus
);
    localparam logic [1:0]       M_WRAP = 2'b00;
    localparam logic [1:0]       M_MOD  = 2'b10;
    localparam logic [1:0]       M_ONE  = 2'b11;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [PRE_W-1:0] PONE   = PRE_W'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic             tick;
    logic             at_bound;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] step_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    // Candidate next count for a tick; bound handling depends on mode.
    always_comb begin
        tick     = bus.en && (pre_q == bus.prescale);
        top      = (bus.mode == M_WRAP) ? '1 : bus.limit;
        at_bound = bus.dir ? (count_q >= top) : (count_q == '0);
        step_val = count_q;
        case (bus.mode)
            M_WRAP:  step_val = bus.dir ? count_q + ONE : count_q - ONE;
            M_MOD: begin
                if (bus.dir) step_val = at_bound ? '0 : count_q + ONE;
                else         step_val = at_bound ? bus.limit : count_q - ONE;
            end
            default: begin
                // saturate and one-shot: an up count above limit clamps to limit
                if (bus.dir) step_val = at_bound ? bus.limit : count_q + ONE;
                else         step_val = at_bound ? '0 : count_q - ONE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (bus.load) begin
            count_d = bus.load_val;
            pre_d   = '0;
            done_d  = 1'b0;
        end else if (bus.en) begin
            // Free-running increment lets a lowered prescale wrap through 2^PRE_W.
            pre_d = tick ? '0 : pre_q + PONE;
            if (tick && !done_q) begin
                count_d = step_val;
                tc_d    = at_bound;
                if (bus.mode == M_ONE && at_bound) done_d = 1'b1;
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_prog_counter_n.sv
// Scenario bench for prog_counter_n: expected count/tc/done tuples are queued
// as stimulus is applied and compared after the clock edge that produces them.
module tb_prog_counter_n;
    typedef struct packed {
        logic [7:0] cnt;
        logic       tc;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    prog_counter_n_if #(.WIDTH(8), .PRE_W(4)) bus();

    prog_counter_n #(.WIDTH(8), .PRE_W(4), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        bus.en = 0; bus.load = 0; bus.load_val = 0; bus.dir = 1;
        bus.mode = 0; bus.limit = 0; bus.prescale = 0;
        #3;
        sb.push_back('{8'h00, 1'b0, 1'b0});
        e = sb.pop_front();
        checks++;
        if ({bus.count, bus.tc, bus.done} !== e) begin
            errors++;
            $display("FAIL reset: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                     bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
        end
        cyc(); cyc();
    endtask

    task automatic test_wrap();
        exp_t e;
        bus.mode = 2'b00; bus.dir = 1; bus.prescale = 0; bus.en = 1;
        rst = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            sb.push_back('{8'(i + 1), (i == 255), 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.done} !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
            end
        end
    endtask

    task automatic test_modulo();
        exp_t e;
        logic [7:0] cexp [7] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd9, 8'd8, 8'd7};
        logic       texp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.mode = 2'b10; bus.limit = 9; bus.dir = 0; bus.en = 1;
        bus.load_val = 3; bus.load = 1;
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{cexp[i], texp[i], 1'b0});
            cyc();
            bus.load = 0;
            e = sb.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.done} !== e) begin
                errors++;
                $display("FAIL modulo[%0d]: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
            end
        end
    endtask

    task automatic test_prescale();
        exp_t e;
        logic       enp  [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] cexp [15] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                                  8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
        bus.mode = 2'b00; bus.dir = 1; bus.prescale = 2;
        bus.load_val = 0; bus.load = 1;
        for (int i = 0; i < 15; i++) begin
            bus.en = enp[i];
            sb.push_back('{cexp[i], 1'b0, 1'b0});
            cyc();
            bus.load = 0;
            e = sb.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.done} !== e) begin
                errors++;
                $display("FAIL prescale[%0d]: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
            end
        end
        bus.en = 1; bus.prescale = 0;
    endtask

    task automatic test_oneshot();
        exp_t e;
        bus.mode = 2'b11; bus.dir = 1; bus.limit = 5; bus.prescale = 0; bus.en = 1;
        for (int i = 0; i < 30; i++) begin
            bus.load     = (i == 0) || (i == 27);
            bus.load_val = (i == 27) ? 8'd2 : 8'd0;
            if (i <= 5)       sb.push_back('{8'(i), 1'b0, 1'b0});
            else if (i == 6)  sb.push_back('{8'd5, 1'b1, 1'b1});
            else if (i <= 26) sb.push_back('{8'd5, 1'b0, 1'b1});
            else              sb.push_back('{8'(i - 25), 1'b0, 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.done} !== e) begin
                errors++;
                $display("FAIL oneshot[%0d]: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
            end
        end
        bus.load = 0;
    endtask

    task automatic test_load_tick_saturate();
        exp_t e;
        bus.prescale = 0; bus.en = 1; bus.limit = 9;
        for (int i = 0; i < 14; i++) begin
            bus.load     = (i == 0) || (i == 11);
            bus.load_val = (i == 0) ? 8'd7 : 8'd20;
            bus.mode     = (i == 0) ? 2'b00 : 2'b01;
            bus.dir      = (i == 0) || (i >= 11);
            if (i == 0)       sb.push_back('{8'd7, 1'b0, 1'b0});
            else if (i <= 10) sb.push_back('{(i <= 7) ? 8'(7 - i) : 8'd0, (i >= 8), 1'b0});
            else if (i == 11) sb.push_back('{8'd20, 1'b0, 1'b0});
            else              sb.push_back('{8'd9, 1'b1, 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.done} !== e) begin
                errors++;
                $display("FAIL load_sat[%0d]: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
            end
        end
        bus.load = 0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        bus.mode = 2'b00; bus.dir = 1; bus.prescale = 0; bus.en = 1;
        bus.load_val = 8'h59; bus.load = 1;
        cyc();
        bus.load = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                sb.push_back('{8'h5A, 1'b0, 1'b0});
                cyc();
            end else if (i == 1) begin
                sb.push_back('{8'h00, 1'b0, 1'b0});
                #2 rst = 1'b1;
                #1;
            end else begin
                sb.push_back('{8'(i - 1), 1'b0, 1'b0});
                cyc();
            end
            e = sb.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.done} !== e) begin
                errors++;
                $display("FAIL async_rst[%0d]: got cnt=%0d tc=%b done=%b, expected cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc, bus.done, e.cnt, e.tc, e.done);
            end
            if (i == 1) #1 rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_modulo();
        test_prescale();
        test_oneshot();
        test_load_tick_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
